// File: rtl/pes_crc_stream_param.sv
// Streaming CRC generator/appender: echoes each beat, then appends the
// frame CRC MSB-chunk-first with m_last on the final chunk.
module pes_crc_stream_param #(
  parameter int               DATA_W  = 8,
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h8005,
  parameter logic [CRC_W-1:0] INIT    = 16'h0000,
  parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [CRC_W-1:0]  crc_value
);

  localparam int NCH   = CRC_W / DATA_W;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    APPEND
  } state_t;

  state_t           state;
  logic [CRC_W-1:0] crc;
  logic [CNT_W-1:0] cnt;
  logic             out_free;
  logic             fire_in;
  logic             fire_out;

  // DATA_W serial LFSR steps unrolled, MSB of the beat first
  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0]  c,
    input logic [DATA_W-1:0] d
  );
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] chunk_of(
    input logic [CRC_W-1:0] c,
    input logic [CNT_W-1:0] n
  );
    logic [CRC_W-1:0] f;
    f = (c ^ XOR_OUT) >> ((NCH - 1 - int'(n)) * DATA_W);
    return f[DATA_W-1:0];
  endfunction

  assign out_free  = !m_valid || m_ready;
  assign s_ready   = out_free && (state != APPEND);
  assign fire_in   = s_valid && s_ready;
  assign fire_out  = m_valid && m_ready;
  assign busy      = (state != IDLE);
  assign crc_value = crc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      crc     <= INIT;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      unique case (state)
        APPEND: begin
          if (out_free) begin
            m_data  <= chunk_of(crc, cnt);
            m_valid <= 1'b1;
            if (cnt == LAST_CNT) begin
              m_last <= 1'b1;
              crc    <= INIT;
              cnt    <= '0;
              state  <= IDLE;
            end else begin
              m_last <= 1'b0;
              cnt    <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (fire_in) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc_step(crc, s_data);
            state   <= s_last ? APPEND : COMPUTE;
          end else if (fire_out) begin
            m_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
